// File: rtl/snow64_long_div_arbiter_pkg.sv
// Shared state encoding and datapath widths for the U16/U8 long-divider arbiter.
package snow64_long_div_arbiter_pkg;
    localparam int WIDTH__DIV_A   = 16;
    localparam int WIDTH__DIV_B   = 8;
    localparam int WIDTH__DIV_OUT = 18;
    localparam int WIDTH__QUOT    = 16;

    typedef logic [1:0] state_t;
    localparam state_t StIdle = 2'd0;
    localparam state_t StWait = 2'd1;
    localparam state_t StResp = 2'd2;
endpackage

// File: rtl/snow64_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above rr_ptr, with wrap-around.
module snow64_rr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH__REQ_IDX = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [WIDTH__REQ_IDX-1:0] rr_ptr,
    input  logic                      enable,
    output logic [NUM_REQ-1:0]        grant,
    output logic [WIDTH__REQ_IDX-1:0] grant_idx,
    output logic                      any_grant
);
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        // Walk from the farthest slot back toward rr_ptr so the nearest request wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (enable && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_idx = WIDTH__REQ_IDX'((int'(rr_ptr) + k) % NUM_REQ);
                any_grant = 1'b1;
            end
        end
        if (any_grant) grant[grant_idx] = 1'b1;
    end
endmodule

// File: rtl/snow64_long_div_u16_by_u8_arbiter.sv
// Shares one radix-8 U16/U8 long divider among NUM_REQ requesters, one division in flight.
//   state  | meaning
//   StIdle | arbitrating; grant, request accept and divider start share one cycle
//   StWait | division in flight, waiting for in_div_data_valid
//   StResp | quotient held for the granted requester until it accepts
module snow64_long_div_u16_by_u8_arbiter
    import snow64_long_div_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH__REQ_IDX = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                in_req_valid,
    input  logic [NUM_REQ*WIDTH__DIV_A-1:0]   in_req_a,
    input  logic [NUM_REQ*WIDTH__DIV_B-1:0]   in_req_b,
    output logic [NUM_REQ-1:0]                out_req_ready,
    output logic [NUM_REQ-1:0]                out_resp_valid,
    output logic [WIDTH__QUOT-1:0]            out_resp_quot,
    output logic                              out_resp_div_by_zero,
    input  logic [NUM_REQ-1:0]                in_resp_ready,
    output logic                              out_div_start,
    output logic [WIDTH__DIV_A-1:0]           out_div_a,
    output logic [WIDTH__DIV_B-1:0]           out_div_b,
    input  logic                              in_div_data_valid,
    input  logic                              in_div_can_accept_cmd,
    input  logic [WIDTH__DIV_OUT-1:0]         in_div_data
);
    state_t                    state;
    logic [WIDTH__REQ_IDX-1:0] rr_ptr;
    logic [WIDTH__REQ_IDX-1:0] grant_idx;
    logic                      dbz;

    logic                      arb_enable;
    logic [NUM_REQ-1:0]        arb_grant;
    logic [WIDTH__REQ_IDX-1:0] arb_idx;
    logic                      arb_any;

    // A 16/8 quotient always fits in 16 bits; the divider's top bits carry nothing useful.
    logic unused_div_hi;
    assign unused_div_hi = ^in_div_data[WIDTH__DIV_OUT-1:WIDTH__QUOT];

    assign arb_enable = !rst && (state == StIdle) && in_div_can_accept_cmd;

    snow64_rr_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .WIDTH__REQ_IDX (WIDTH__REQ_IDX)
    ) u_rr_arbiter (
        .req       (in_req_valid),
        .rr_ptr    (rr_ptr),
        .enable    (arb_enable),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    always_comb begin
        out_req_ready = arb_grant;
        out_div_start = arb_any;
        out_div_a     = '0;
        out_div_b     = '0;
        if (arb_any) begin
            out_div_a = in_req_a[int'(arb_idx)*WIDTH__DIV_A +: WIDTH__DIV_A];
            out_div_b = in_req_b[int'(arb_idx)*WIDTH__DIV_B +: WIDTH__DIV_B];
        end
        out_resp_valid = '0;
        if (!rst && state == StResp) out_resp_valid[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= StIdle;
            rr_ptr               <= '0;
            grant_idx            <= '0;
            dbz                  <= 1'b0;
            out_resp_quot        <= '0;
            out_resp_div_by_zero <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (arb_any) begin
                        grant_idx <= arb_idx;
                        dbz       <= (out_div_b == '0);
                        rr_ptr    <= (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
                        state     <= StWait;
                    end
                end
                StWait: begin
                    if (in_div_data_valid) begin
                        out_resp_quot        <= in_div_data[WIDTH__QUOT-1:0];
                        out_resp_div_by_zero <= dbz;
                        state                <= StResp;
                    end
                end
                StResp: begin
                    if (in_resp_ready[grant_idx]) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_snow64_long_div_u16_by_u8_arbiter.sv
// Self-checking bench: behavioural 6-cycle divider plus a round-robin/arithmetic reference model.
module tb_snow64_long_div_u16_by_u8_arbiter;
    localparam int NUM_REQ = 4;
    localparam int LAT     = 7;   // edges from the accept edge until the response is visible
    localparam int BUDGET  = 40;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    in_req_valid = '0;
    logic [NUM_REQ*16-1:0] in_req_a = '0;
    logic [NUM_REQ*8-1:0]  in_req_b = '0;
    logic [NUM_REQ-1:0]    out_req_ready;
    logic [NUM_REQ-1:0]    out_resp_valid;
    logic [15:0]           out_resp_quot;
    logic                  out_resp_div_by_zero;
    logic [NUM_REQ-1:0]    in_resp_ready = '1;
    logic                  out_div_start;
    logic [15:0]           out_div_a;
    logic [7:0]            out_div_b;
    logic                  in_div_data_valid = 1'b0;
    logic                  in_div_can_accept_cmd;
    logic [17:0]           in_div_data = '0;

    logic        div_busy  = 1'b0;
    logic        div_block = 1'b0;
    int          div_cnt   = 0;
    logic [17:0] div_res   = '0;
    int          cyc       = 0;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_ptr  = 0;
    logic        req_v [NUM_REQ];
    logic [15:0] req_a [NUM_REQ];
    logic [7:0]  req_b [NUM_REQ];

    snow64_long_div_u16_by_u8_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .in_req_valid          (in_req_valid),
        .in_req_a              (in_req_a),
        .in_req_b              (in_req_b),
        .out_req_ready         (out_req_ready),
        .out_resp_valid        (out_resp_valid),
        .out_resp_quot         (out_resp_quot),
        .out_resp_div_by_zero  (out_resp_div_by_zero),
        .in_resp_ready         (in_resp_ready),
        .out_div_start         (out_div_start),
        .out_div_a             (out_div_a),
        .out_div_b             (out_div_b),
        .in_div_data_valid     (in_div_data_valid),
        .in_div_can_accept_cmd (in_div_can_accept_cmd),
        .in_div_data           (in_div_data)
    );

    always #5 clk = ~clk;

    // Divider model: result valid is raised on the 6th edge after the start edge, with junk top bits.
    assign in_div_can_accept_cmd = !div_busy && !div_block;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_div_start) begin
            div_busy          <= 1'b1;
            in_div_data_valid <= 1'b0;
            div_cnt           <= 5;
            div_res           <= (out_div_b == 8'd0) ? 18'd0 : 18'(out_div_a / 16'(out_div_b));
        end else if (div_busy) begin
            if (div_cnt == 0) begin
                div_busy          <= 1'b0;
                in_div_data_valid <= 1'b1;
                in_div_data       <= {2'($urandom_range(0, 3)), div_res[15:0]};
            end else begin
                div_cnt <= div_cnt - 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
        $fatal(1);
    end

    function automatic logic [15:0] ref_quot(input logic [15:0] a, input logic [7:0] b);
        return (b == 8'd0) ? 16'd0 : a / 16'(b);
    endfunction

    function automatic int ref_pick(input int ptr);
        int p;
        p = -1;
        for (int k = 0; k < NUM_REQ; k++)
            if (p < 0 && req_v[(ptr + k) % NUM_REQ]) p = (ptr + k) % NUM_REQ;
        return p;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < NUM_REQ; k++) begin
            req_v[k] = 1'b0;
            req_a[k] = '0;
            req_b[k] = '0;
        end
    endtask

    task automatic new_op(input int k, input bit allow_zero);
        req_v[k] = 1'b1;
        req_a[k] = 16'($urandom);
        req_b[k] = (allow_zero && $urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    endtask

    task automatic apply_reqs();
        for (int k = 0; k < NUM_REQ; k++) begin
            in_req_valid[k]       = req_v[k];
            in_req_a[k*16 +: 16]  = req_a[k];
            in_req_b[k*8 +: 8]    = req_b[k];
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        exp_ptr = 0;
    endtask

    task automatic wait_grant(input int budget, output int g, output bit ok);
        int n;
        n = 0; ok = 1'b0; g = -1;
        while (!ok && n < budget) begin
            if (out_req_ready != '0) begin
                ok = 1'b1;
                for (int k = 0; k < NUM_REQ; k++) if (out_req_ready[k]) g = k;
            end else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic wait_resp(input int budget, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (!ok && n < budget) begin
            if (out_resp_valid != '0) ok = 1'b1;
            else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic test_reset();
        clear_reqs();
        for (int k = 0; k < NUM_REQ; k++) new_op(k, 1'b0);
        apply_reqs();
        tick();
        tick();
        n_checks++; if (out_req_ready !== '0) $display("FAIL rst_ready: got %b want 0", out_req_ready); else n_pass++;
        n_checks++; if (out_div_start !== 1'b0) $display("FAIL rst_start: got %b want 0", out_div_start); else n_pass++;
        n_checks++; if (out_div_a !== '0 || out_div_b !== '0) $display("FAIL rst_operands: got %h/%h want 0/0", out_div_a, out_div_b); else n_pass++;
        n_checks++; if (out_resp_valid !== '0) $display("FAIL rst_resp_valid: got %b want 0", out_resp_valid); else n_pass++;
        n_checks++; if (out_resp_quot !== '0 || out_resp_div_by_zero !== 1'b0) $display("FAIL rst_quot: got %h/%b want 0/0", out_resp_quot, out_resp_div_by_zero); else n_pass++;
        rst = 1'b0;
        clear_reqs();
        apply_reqs();
        tick();
        exp_ptr = 0;
        n_checks++; if (out_div_start !== 1'b0 || out_req_ready !== '0) $display("FAIL idle_no_req: got start=%b ready=%b want 0", out_div_start, out_req_ready); else n_pass++;
        n_checks++; if (out_resp_quot !== '0) $display("FAIL idle_quot: got %h want 0", out_resp_quot); else n_pass++;
    endtask

    task automatic test_single();
        int g, n;
        bit ok;
        clear_reqs();
        req_v[0] = 1'b1; req_a[0] = 16'd1000; req_b[0] = 8'd7;
        apply_reqs();
        wait_grant(BUDGET, g, ok);
        n_checks++; if (!ok || g != 0) begin $display("FAIL single_grant: got %0d want 0", g); return; end else n_pass++;
        n_checks++; if (out_div_start !== 1'b1 || out_div_a !== 16'd1000 || out_div_b !== 8'd7)
            $display("FAIL single_start: got %b %0d/%0d want 1 1000/7", out_div_start, out_div_a, out_div_b); else n_pass++;
        tick();
        clear_reqs();
        apply_reqs();
        n_checks++; if (out_div_start !== 1'b0 || out_div_a !== '0) $display("FAIL single_start_low: got %b %h want 0 0", out_div_start, out_div_a); else n_pass++;
        wait_resp(BUDGET, n, ok);
        n_checks++; if (!ok || n != LAT) $display("FAIL single_latency: got %0d want %0d", n, LAT); else n_pass++;
        n_checks++; if (out_resp_valid !== 4'b0001) $display("FAIL single_valid: got %b want 0001", out_resp_valid); else n_pass++;
        n_checks++; if (out_resp_quot !== 16'h008E || out_resp_div_by_zero !== 1'b0)
            $display("FAIL single_quot: got %h/%b want 008e/0", out_resp_quot, out_resp_div_by_zero); else n_pass++;
        tick();
        n_checks++; if (out_resp_valid !== '0) $display("FAIL single_release: got %b want 0", out_resp_valid); else n_pass++;
        exp_ptr = 1;
    endtask

    task automatic test_two_req();
        int g, n, eg;
        bit ok;
        logic [15:0] ea;
        logic [7:0] eb;
        do_reset();
        clear_reqs();
        new_op(0, 1'b0);
        req_v[2] = 1'b1; req_a[2] = 16'hFFFF; req_b[2] = 8'hFF;
        apply_reqs();
        for (int t = 0; t < 2; t++) begin
            eg = ref_pick(exp_ptr);
            wait_grant(BUDGET, g, ok);
            n_checks++; if (!ok || g != eg || g != 2 * t) begin $display("FAIL two_order: got %0d want %0d", g, 2 * t); return; end else n_pass++;
            ea = req_a[g]; eb = req_b[g];
            tick();
            req_v[g] = 1'b0;
            apply_reqs();
            wait_resp(BUDGET, n, ok);
            n_checks++; if (!ok || n != LAT) $display("FAIL two_latency: got %0d want %0d", n, LAT); else n_pass++;
            n_checks++; if (out_resp_quot !== ref_quot(ea, eb)) $display("FAIL two_quot: got %0d want %0d", out_resp_quot, ref_quot(ea, eb)); else n_pass++;
            tick();
            exp_ptr = (g + 1) % NUM_REQ;
        end
        n_checks++; if (out_resp_quot !== 16'd257) $display("FAIL two_req2_quot: got %0d want 257", out_resp_quot); else n_pass++;
    endtask

    task automatic test_div_by_zero();
        int g, n;
        bit ok;
        do_reset();
        clear_reqs();
        req_v[1] = 1'b1; req_a[1] = 16'h1234; req_b[1] = 8'd0;
        apply_reqs();
        wait_grant(BUDGET, g, ok);
        n_checks++; if (!ok || g != 1) begin $display("FAIL dbz_grant: got %0d want 1", g); return; end else n_pass++;
        tick();
        clear_reqs();
        apply_reqs();
        wait_resp(BUDGET, n, ok);
        n_checks++; if (!ok || out_resp_valid !== 4'b0010) $display("FAIL dbz_valid: got %b want 0010", out_resp_valid); else n_pass++;
        n_checks++; if (out_resp_quot !== 16'd0 || out_resp_div_by_zero !== 1'b1)
            $display("FAIL dbz_result: got %h/%b want 0000/1", out_resp_quot, out_resp_div_by_zero); else n_pass++;
        tick();
        exp_ptr = 2;
    endtask

    task automatic test_round_robin();
        int g, n, last_cyc;
        bit ok;
        logic [15:0] ea;
        logic [7:0] eb;
        do_reset();
        clear_reqs();
        for (int k = 0; k < NUM_REQ; k++) new_op(k, 1'b1);
        apply_reqs();
        last_cyc = 0;
        for (int t = 0; t < 8; t++) begin
            wait_grant(BUDGET, g, ok);
            n_checks++; if (!ok || g != t % NUM_REQ || g != ref_pick(exp_ptr)) begin
                $display("FAIL rr_order: txn %0d got %0d want %0d", t, g, t % NUM_REQ); return; end else n_pass++;
            if (t > 0) begin
                n_checks++; if (cyc - last_cyc != 9) $display("FAIL rr_throughput: got %0d cycles want 9", cyc - last_cyc); else n_pass++;
            end
            last_cyc = cyc;
            ea = req_a[g]; eb = req_b[g];
            tick();
            new_op(g, 1'b1);
            apply_reqs();
            wait_resp(BUDGET, n, ok);
            n_checks++; if (!ok || out_resp_quot !== ref_quot(ea, eb) || out_resp_div_by_zero !== (eb == 8'd0))
                $display("FAIL rr_result: got %h/%b want %h/%b", out_resp_quot, out_resp_div_by_zero, ref_quot(ea, eb), eb == 8'd0); else n_pass++;
            tick();
            exp_ptr = (g + 1) % NUM_REQ;
        end
        clear_reqs();
        apply_reqs();
    endtask

    task automatic test_backpressure();
        int g, n;
        bit ok;
        logic [15:0] eq;
        do_reset();
        clear_reqs();
        new_op(0, 1'b0);
        new_op(1, 1'b0);
        eq = ref_quot(req_a[0], req_b[0]);
        apply_reqs();
        in_resp_ready = 4'b1110;
        wait_grant(BUDGET, g, ok);
        n_checks++; if (!ok || g != 0) begin $display("FAIL bp_grant: got %0d want 0", g); return; end else n_pass++;
        tick();
        req_v[0] = 1'b0;
        apply_reqs();
        wait_resp(BUDGET, n, ok);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (out_resp_valid !== 4'b0001 || out_resp_quot !== eq || out_div_start !== 1'b0)
                $display("FAIL bp_hold: cycle %0d got %b %h start=%b want 0001 %h start=0", i, out_resp_valid, out_resp_quot, out_div_start, eq); else n_pass++;
            tick();
        end
        in_resp_ready = '1;
        #1;
        n_checks++; if (out_resp_valid !== 4'b0001) $display("FAIL bp_valid_before_edge: got %b want 0001", out_resp_valid); else n_pass++;
        tick();
        n_checks++; if (out_resp_valid !== '0 || out_div_start !== 1'b1 || out_req_ready !== 4'b0010)
            $display("FAIL bp_next_grant: got valid=%b start=%b ready=%b want 0000 1 0010", out_resp_valid, out_div_start, out_req_ready); else n_pass++;
        eq = ref_quot(req_a[1], req_b[1]);
        tick();
        clear_reqs();
        apply_reqs();
        wait_resp(BUDGET, n, ok);
        n_checks++; if (!ok || out_resp_valid !== 4'b0010 || out_resp_quot !== eq)
            $display("FAIL bp_second: got %b %h want 0010 %h", out_resp_valid, out_resp_quot, eq); else n_pass++;
        tick();
        exp_ptr = 2;
    endtask

    task automatic test_random();
        int g, n, eg, d, nv;
        bit ok;
        logic [15:0] ea;
        logic [7:0] eb;
        logic [NUM_REQ-1:0] oh;
        do_reset();
        clear_reqs();
        for (int t = 0; t < 20; t++) begin
            nv = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!req_v[k] && $urandom_range(0, 1) == 1) new_op(k, 1'b1);
                else if (req_v[k] && $urandom_range(0, 7) == 0) req_v[k] = 1'b0;
                if (req_v[k]) nv++;
            end
            if (nv == 0) new_op(int'($urandom_range(0, NUM_REQ - 1)), 1'b1);
            apply_reqs();
            eg = ref_pick(exp_ptr);
            wait_grant(BUDGET, g, ok);
            n_checks++; if (!ok || g != eg) begin $display("FAIL rand_grant: txn %0d got %0d want %0d", t, g, eg); return; end else n_pass++;
            ea = req_a[g]; eb = req_b[g];
            oh = '0; oh[g] = 1'b1;
            in_resp_ready = NUM_REQ'($urandom) & ~oh;
            tick();
            req_v[g] = 1'b0;
            apply_reqs();
            wait_resp(BUDGET, n, ok);
            n_checks++; if (!ok || n != LAT || out_resp_valid !== oh) $display("FAIL rand_resp: got lat=%0d valid=%b want %0d %b", n, out_resp_valid, LAT, oh); else n_pass++;
            d = int'($urandom_range(0, 3));
            for (int i = 0; i < d; i++) tick();
            n_checks++; if (out_resp_valid !== oh || out_resp_quot !== ref_quot(ea, eb) || out_resp_div_by_zero !== (eb == 8'd0))
                $display("FAIL rand_result: got %b %h/%b want %b %h/%b", out_resp_valid, out_resp_quot, out_resp_div_by_zero, oh, ref_quot(ea, eb), eb == 8'd0); else n_pass++;
            in_resp_ready[g] = 1'b1;
            #1;
            tick();
            n_checks++; if (out_resp_valid !== '0) $display("FAIL rand_release: got %b want 0", out_resp_valid); else n_pass++;
            exp_ptr = (g + 1) % NUM_REQ;
        end
        in_resp_ready = '1;
        clear_reqs();
        apply_reqs();
    endtask

    task automatic test_reset_mid_op();
        int g, n;
        bit ok;
        do_reset();
        clear_reqs();
        new_op(1, 1'b0);
        apply_reqs();
        wait_grant(BUDGET, g, ok);
        n_checks++; if (!ok || g != 1) begin $display("FAIL mid_grant: got %0d want 1", g); return; end else n_pass++;
        tick();
        clear_reqs();
        apply_reqs();
        tick();
        tick();
        rst = 1'b1;
        div_block = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        #1;
        exp_ptr = 0;
        n_checks++; if (out_resp_valid !== '0 || out_resp_quot !== '0 || out_resp_div_by_zero !== 1'b0)
            $display("FAIL mid_rst_outputs: got %b %h/%b want 0 0/0", out_resp_valid, out_resp_quot, out_resp_div_by_zero); else n_pass++;
        req_v[0] = 1'b1; req_a[0] = 16'd100; req_b[0] = 8'd10;
        apply_reqs();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_div_start !== 1'b0 || out_req_ready !== '0 || out_div_a !== '0)
                $display("FAIL mid_blocked: cycle %0d got start=%b ready=%b a=%h want 0", i, out_div_start, out_req_ready, out_div_a); else n_pass++;
            tick();
        end
        div_block = 1'b0;
        #1;
        wait_grant(BUDGET, g, ok);
        n_checks++; if (!ok || g != 0 || out_div_a !== 16'd100 || out_div_b !== 8'd10)
            begin $display("FAIL mid_regrant: got %0d %0d/%0d want 0 100/10", g, out_div_a, out_div_b); return; end else n_pass++;
        tick();
        clear_reqs();
        apply_reqs();
        wait_resp(BUDGET, n, ok);
        n_checks++; if (!ok || n != LAT || out_resp_valid !== 4'b0001 || out_resp_quot !== 16'd10 || out_resp_div_by_zero !== 1'b0)
            $display("FAIL mid_result: got lat=%0d %b %0d/%b want %0d 0001 10/0", n, out_resp_valid, out_resp_quot, out_resp_div_by_zero, LAT); else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_req();
        test_div_by_zero();
        test_round_robin();
        test_backpressure();
        test_random();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/snow64_long_div_u16_by_u8_arbiter.md
Name: snow64_long_div_u16_by_u8_arbiter

Overview:
Shares one radix-8 U16-by-U8 long divider among NUM_REQ requesters, for example the scalar and vector ALU lanes. It runs round-robin arbitration, drives the divider's start/operand interface and waits for the divider's result. It then returns the quotient to the winning requester over a valid/ready response channel. Only one division is in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH__REQ_IDX, $clog2(NUM_REQ), width of the grant index

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_req_valid  in  NUM_REQ  per-requester request valid
in_req_a  in  NUM_REQ*16  packed dividends; requester k uses bits [16k+15:16k]
in_req_b  in  NUM_REQ*8  packed divisors; requester k uses bits [8k+7:8k]
out_req_ready  out  NUM_REQ  one-hot request accept (combinational)
out_resp_valid  out  NUM_REQ  one-hot response valid
out_resp_quot  out  16  quotient, shared across requesters
out_resp_div_by_zero  out  1  set when the captured divisor was 0
in_resp_ready  in  NUM_REQ  per-requester response ready
out_div_start  out  1  divider start pulse
out_div_a  out  16  divider dividend
out_div_b  out  8  divider divisor
in_div_data_valid  in  1  divider result valid (level; cleared by the divider on the accepting start edge)
in_div_can_accept_cmd  in  1  divider idle
in_div_data  in  18  divider result

Behaviour:
- States: StIdle, StWait, StResp. Reset puts the block in StIdle with rr_ptr=0 and grant=0.
- Reset values: all outputs 0. out_resp_quot and out_resp_div_by_zero are held at 0 until the first capture.
- StIdle, grant condition: |in_req_valid and in_div_can_accept_cmd.
- StIdle, requester choice: pick the first requester with valid set, searching from rr_ptr upward with wrap-around.
- StIdle, same cycle as the grant:
  - out_req_ready[g]=1 (the request transfer happens here).
  - out_div_start=1.
  - out_div_a/out_div_b = operands of requester g.
- StIdle, on the edge: latch g; latch dbz=(b==0); set rr_ptr=(g+1) mod NUM_REQ; go to StWait.
- StIdle with no request, or with in_div_can_accept_cmd=0: no start and no ready.
- out_div_start is 1 only during the granting StIdle cycle. out_div_a/out_div_b are 0 whenever start=0.
- StWait: stay until in_div_data_valid=1. Then capture out_resp_quot=in_div_data[15:0] and out_resp_div_by_zero=dbz, and go to StResp.
- A nonzero in_div_data[17:16] is ignored, because a 16/8 quotient fits in 16 bits.
- StResp:
  - out_resp_valid[g]=1; quot and dbz held stable.
  - If in_resp_ready[g]=1 on an edge, transfer the response, clear valid and go to StIdle.
  - No new grant is issued in the StResp cycle itself.
- in_resp_ready of non-granted requesters is ignored.
- Latency with the current divider: start edge at cycle 0, in_div_data_valid high after edge 6, capture at edge 7, so out_resp_valid is visible from cycle 7.
- Back-to-back throughput: one division per 9 cycles when in_resp_ready is held high.
- Divide by zero: the divider returns 0, so quot=0 and dbz=1.
- Reset mid-operation: returns to StIdle immediately and discards any pending response.
- The divider has no reset. After reset the arbiter issues nothing until in_div_can_accept_cmd=1.
- A stale in_div_data_valid level from before reset is harmless: it is only sampled in StWait, and the divider clears it on the start edge.
- Requester protocol: operands must be stable while in_req_valid=1 and not yet accepted. A requester dropping valid before accept is permitted and is not granted.

Decomposition:
- Shared package snow64_long_div_arbiter_pkg holds:
  - the state enum;
  - the constants WIDTH__DIV_A=16, WIDTH__DIV_B=8, WIDTH__DIV_OUT=18, WIDTH__QUOT=16.
- These widths are also mirrored in the long-div defines header.
- Sub-module snow64_rr_arbiter (parameter NUM_REQ):
  - inputs: request vector, rr_ptr, enable;
  - outputs: one-hot grant, grant index, any_grant;
  - purely combinational.
- A behavioural divider model in the bench mimics the 6-working-cycle protocol.

Test Plan:
1. Req0 with a=1000, b=7. Expect accept at cycle 0, resp_valid[0] at cycle 7, quot=0x008E (142), dbz=0.
2. Req0 and req2 both valid with rr_ptr=0. Expect grant order 0 then 2. Req2 a=0xFFFF, b=0xFF gives quot=257.
3. Req1 with a=0x1234, b=0. Expect quot=0, dbz=1.
4. All four requesters held valid for 8 divisions. Expect grant order 0,1,2,3,0,1,2,3 with no starvation.
5. Response backpressure: in_resp_ready[0]=0 for 5 cycles after valid. Expect valid and quot held stable, no out_div_start issued, StIdle entered one edge after ready.
6. Reset asserted in StWait, then in_div_can_accept_cmd held at 0 for 3 cycles. Expect all outputs 0, no start until can_accept=1, and the next request completes correctly (a=100, b=10 gives quot=10).
